// File: rtl/beep_pkg.sv
// Shared definitions for the key beep transmitter and receiver:
// FSM state type, beep timing constants and default decode thresholds.
package beep_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SYMBOL = 1'b1
    } state_t;

    localparam int BEEP_DURATION        = 16;
    localparam int SHORT_PAUSE_DURATION = 8;
    localparam int SYMBOL_LEN           = 32;

    // A '1' carries 24 high cycles and a '0' 16; 20 splits them evenly.
    localparam int ONE_THRESH = 20;
    // Fewer high cycles than this in a window means the carrier is gone.
    localparam int MIN_HIGH   = 8;

    // 2-of-3 vote used by the optional glitch filter.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/ant_sync_filter.sv
// Brings the asynchronous antenna line into the clk domain and flags
// rising edges of the conditioned signal.
// Optional macro BEEP_RECEIVE_GLITCH_FILTER_EN adds a 3-tap majority
// filter after the synchronizer (one extra cycle of latency).
module ant_sync_filter
    import beep_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ant_in,
    output logic ant_s,
    output logic ant_rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic ant_prev_reg;

    // Two-flop synchronizer against metastability on ant_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= ant_in;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef BEEP_RECEIVE_GLITCH_FILTER_EN
    logic [1:0] tap_reg;

    // Keep the two previous synced samples for the majority vote.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_reg <= 2'b00;
        end else begin
            tap_reg <= {tap_reg[0], sync2_reg};
        end
    end

    // A lone high or low sample never wins the vote, so 1-cycle glitches vanish.
    assign ant_s = majority3(sync2_reg, tap_reg[0], tap_reg[1]);
`else
    assign ant_s = sync2_reg;
`endif

    // Previous conditioned value, for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            ant_prev_reg <= 1'b0;
        end else begin
            ant_prev_reg <= ant_s;
        end
    end

    assign ant_rise = ant_s & ~ant_prev_reg;

endmodule

// File: rtl/beep_receive.sv
// Beep-stream demodulator: classifies each SYMBOL_LEN-cycle window by its
// high-cycle count and assembles KEY_BITS bits (MSB first) into key_out.
// Optional macro BEEP_RECEIVE_GLITCH_FILTER_EN enables the input glitch
// filter inside ant_sync_filter.
module beep_receive
    import beep_pkg::*;
#(
    parameter int KEY_BITS   = 256,
    parameter int SYMBOL_LEN = beep_pkg::SYMBOL_LEN,
    parameter int ONE_THRESH = beep_pkg::ONE_THRESH,
    parameter int MIN_HIGH   = beep_pkg::MIN_HIGH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx_en,
    input  logic                          ant_in,
    output logic [KEY_BITS-1:0]           key_out,
    output logic                          key_valid,
    output logic                          frame_err,
    output logic                          busy,
    output logic [$clog2(KEY_BITS+1)-1:0] bit_count
);

    localparam int SC_W = $clog2(SYMBOL_LEN);
    localparam int HC_W = $clog2(SYMBOL_LEN + 1);
    localparam int BC_W = $clog2(KEY_BITS + 1);

    logic ant_s;
    logic ant_rise;

    ant_sync_filter u_sync (
        .clk      (clk),
        .reset    (reset),
        .ant_in   (ant_in),
        .ant_s    (ant_s),
        .ant_rise (ant_rise)
    );

    state_t              state_reg;
    logic [SC_W-1:0]     sym_cnt_reg;
    logic [HC_W-1:0]     high_cnt_reg;
    logic [KEY_BITS-2:0] shift_reg;   // earlier bits; the last bit joins on completion
    logic [KEY_BITS-1:0] key_out_reg;
    logic                key_valid_reg;
    logic                frame_err_reg;
    logic [BC_W-1:0]     bit_count_reg;

    logic [HC_W-1:0]     high_next;
    logic                bit_val;
    logic                window_end;

    // High count including this cycle's sample, saturating at a full window.
    always_comb begin
        high_next = high_cnt_reg;
        if (ant_s && (high_cnt_reg != HC_W'(SYMBOL_LEN))) begin
            high_next = high_cnt_reg + HC_W'(1);
        end
    end

    assign bit_val    = (high_next >= HC_W'(ONE_THRESH));
    assign window_end = (sym_cnt_reg == SC_W'(SYMBOL_LEN - 1));

    // Receive FSM: frame start, per-window decode, frame completion and abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            sym_cnt_reg   <= '0;
            high_cnt_reg  <= '0;
            shift_reg     <= '0;
            key_out_reg   <= '0;
            key_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            bit_count_reg <= '0;
        end else begin
            key_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rx_en && ant_rise) begin
                        // The edge cycle itself is the first sample of bit 0.
                        state_reg     <= SYMBOL;
                        sym_cnt_reg   <= SC_W'(1);
                        high_cnt_reg  <= HC_W'(1);
                        bit_count_reg <= '0;
                        shift_reg     <= '0;
                    end
                end
                SYMBOL: begin
                    if (!rx_en) begin
                        state_reg     <= IDLE;
                        bit_count_reg <= '0;
                    end else if (window_end) begin
                        sym_cnt_reg  <= '0;
                        high_cnt_reg <= '0;
                        if (high_next < HC_W'(MIN_HIGH)) begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= IDLE;
                            bit_count_reg <= '0;
                        end else if (bit_count_reg == BC_W'(KEY_BITS - 1)) begin
                            key_out_reg   <= {shift_reg, bit_val};
                            key_valid_reg <= 1'b1;
                            state_reg     <= IDLE;
                            bit_count_reg <= '0;
                        end else begin
                            shift_reg     <= {shift_reg[KEY_BITS-3:0], bit_val};
                            bit_count_reg <= bit_count_reg + BC_W'(1);
                        end
                    end else begin
                        sym_cnt_reg  <= sym_cnt_reg + SC_W'(1);
                        high_cnt_reg <= high_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign key_out   = key_out_reg;
    assign key_valid = key_valid_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg == SYMBOL);
    assign bit_count = bit_count_reg;

endmodule

// File: tb/tb_beep_receive.sv
// Directed bench for beep_receive: table of full frames plus hand-written
// error, rx_en-abort and mid-frame reset sequences.
module tb_beep_receive;

    localparam int KB = 256;
    localparam int SL = 32;
`ifdef BEEP_RECEIVE_GLITCH_FILTER_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_en;
    logic          ant_in;
    logic [KB-1:0] key_out;
    logic          key_valid;
    logic          frame_err;
    logic          busy;
    logic [8:0]    bit_count;

    beep_receive dut (
        .clk       (clk),
        .reset     (reset),
        .rx_en     (rx_en),
        .ant_in    (ant_in),
        .key_out   (key_out),
        .key_valid (key_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .bit_count (bit_count)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Strobe and bit_count monitor, sampled 1 time unit after each edge.
    int         kv_cnt = 0, fe_cnt = 0, kv_cyc = -1, fe_cyc = -1;
    int         bc_bad = 0, bc_max = 0;
    logic [8:0] bc_prev = '0;
    always @(posedge clk) begin
        #1;
        if (key_valid) begin kv_cnt++; kv_cyc = cyc; end
        if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
        if (bit_count != bc_prev && bit_count != bc_prev + 9'd1 && bit_count != 9'd0) bc_bad++;
        if (int'(bit_count) > bc_max) bc_max = int'(bit_count);
        bc_prev = bit_count;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [KB-1:0] act, input logic [KB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: clean; 1: 1-cycle glitch in '0' low phase; 2: 5-cycle glitch in '0' low phase.
    task automatic drive_bit(input logic b, input int mode);
        for (int i = 0; i < SL; i++) begin
            ant_in = (i < 16) || (b && i >= 24)
                   || (!b && mode == 1 && i == 24)
                   || (!b && mode == 2 && i >= 20 && i < 25);
            tick(1);
        end
    endtask

    task automatic drive_bits(input logic [KB-1:0] key, input int nbits, input int mode);
        for (int i = 0; i < nbits; i++) drive_bit(key[KB-1-i], mode);
    endtask

    typedef struct {
        logic [KB-1:0] key;
        int            mode;
        logic [KB-1:0] exp;
    } vec_t;

    vec_t vecs[5];

    task automatic run_frame(input int idx);
        int c0, kv0, fe0;
        kv0 = kv_cnt; fe0 = fe_cnt;
        bc_max = 0; bc_bad = 0;
        c0 = cyc;
        drive_bits(vecs[idx].key, KB, vecs[idx].mode);
        ant_in = 1'b0;
        tick(10);
        check($sformatf("v%0d_key_out", idx), key_out, vecs[idx].exp);
        check($sformatf("v%0d_kv_pulses", idx), KB'(kv_cnt - kv0), KB'(1));
        check($sformatf("v%0d_fe_pulses", idx), KB'(fe_cnt - fe0), KB'(0));
        check($sformatf("v%0d_kv_time", idx), KB'(kv_cyc - c0), KB'(LAT + KB * SL));
        check($sformatf("v%0d_bc_max", idx), KB'(bc_max), KB'(KB - 1));
        check($sformatf("v%0d_bc_step", idx), KB'(bc_bad), KB'(0));
        check($sformatf("v%0d_bc_end", idx), KB'(bit_count), KB'(0));
        check($sformatf("v%0d_busy_end", idx), KB'(busy), KB'(0));
        $display("frame %0d mode %0d: key_out=%h", idx, vecs[idx].mode, key_out);
    endtask

    logic [KB-1:0] prev_key;
    logic [KB-1:0] pat;
    int c0, kv0, fe0;

    initial begin
        vecs[0] = '{key: '0, mode: 0, exp: '0};
        vecs[1] = '{key: {1'b1, 254'd0, 1'b1}, mode: 0, exp: {1'b1, 254'd0, 1'b1}};
        vecs[2] = '{key: {32{8'hA5}}, mode: 0, exp: {32{8'hA5}}};
        vecs[3] = '{key: {32{8'hA5}}, mode: 1, exp: {32{8'hA5}}};
        vecs[4] = '{key: {32{8'hF0}}, mode: 2, exp: {KB{1'b1}}};
        pat = {32{8'hC3}};

        reset = 1'b1; rx_en = 1'b1; ant_in = 1'b0;
        tick(3);
        check("rst_key_out", key_out, '0);
        check("rst_key_valid", KB'(key_valid), '0);
        check("rst_frame_err", KB'(frame_err), '0);
        check("rst_busy", KB'(busy), '0);
        check("rst_bit_count", KB'(bit_count), '0);
        reset = 1'b0;
        tick(5);
        $display("reset: key_out=%h busy=%0b bit_count=%0d", key_out, busy, bit_count);

        for (int i = 0; i < 3; i++) run_frame(i);

        // Carrier loss: 10 good bits, then a silent window 11.
        prev_key = key_out;
        kv0 = kv_cnt; fe0 = fe_cnt;
        c0 = cyc;
        drive_bits(pat, 10, 0);
        ant_in = 1'b0;
        tick(SL + 10);
        check("err_fe_pulses", KB'(fe_cnt - fe0), KB'(1));
        check("err_fe_time", KB'(fe_cyc - c0), KB'(LAT + 11 * SL));
        check("err_kv_pulses", KB'(kv_cnt - kv0), KB'(0));
        check("err_key_held", key_out, prev_key);
        check("err_busy", KB'(busy), KB'(0));
        check("err_bit_count", KB'(bit_count), KB'(0));
        $display("carrier loss: frame_err pulses=%0d busy=%0b", fe_cnt - fe0, busy);

        // rx_en dropped after 100 accepted bits.
        kv0 = kv_cnt; fe0 = fe_cnt;
        drive_bits(pat, 100, 0);
        ant_in = 1'b1;
        tick(5);
        check("abort_bc_before", KB'(bit_count), KB'(100));
        check("abort_busy_before", KB'(busy), KB'(1));
        rx_en = 1'b0;
        tick(2);
        check("abort_busy", KB'(busy), KB'(0));
        check("abort_bit_count", KB'(bit_count), KB'(0));
        ant_in = 1'b0;
        tick(6);
        rx_en = 1'b1;
        tick(2);
        check("abort_kv_pulses", KB'(kv_cnt - kv0), KB'(0));
        check("abort_fe_pulses", KB'(fe_cnt - fe0), KB'(0));
        check("abort_key_held", key_out, prev_key);
        $display("rx_en abort: busy=%0b bit_count=%0d", busy, bit_count);

        // Reset in the middle of a frame.
        kv0 = kv_cnt; fe0 = fe_cnt;
        drive_bits(pat, 50, 0);
        ant_in = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        ant_in = 1'b0;
        tick(SL + 5);
        check("mrst_key_out", key_out, '0);
        check("mrst_busy", KB'(busy), KB'(0));
        check("mrst_bit_count", KB'(bit_count), KB'(0));
        check("mrst_kv_pulses", KB'(kv_cnt - kv0), KB'(0));
        check("mrst_fe_pulses", KB'(fe_cnt - fe0), KB'(0));
        $display("mid-frame reset: key_out=%h busy=%0b", key_out, busy);

        for (int i = 3; i < 5; i++) run_frame(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
